// File: rtl/johnson_decoder_checker_pkg.sv
// Shared definitions for Johnson-code consumers: lock FSM states and index sizing.
package johnson_decoder_checker_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    TRACK    = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  // Width needed to hold an index 0..2n-1 of an n-bit Johnson sequence.
  function automatic int unsigned idx_width(input int unsigned n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson-code decoder: legality check and binary index.
module johnson_code_decode
  import johnson_decoder_checker_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  q,
  output logic          legal,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] trans;
  logic [IW-1:0] ones;

  always_comb begin
    trans = '0;
    ones  = '0;
    for (int unsigned i = 1; i < N; i++) begin
      if (q[i] != q[i-1]) trans = trans + IW'(1);
    end
    for (int unsigned i = 0; i < N; i++) begin
      ones = ones + IW'(q[i]);
    end
    legal = (trans <= IW'(1));
    // Second half of the sequence counts down as ones drain out: idx = 2N - k.
    idx = q[0] ? (IW'(2 * N) - ones) : ones;
  end

endmodule

// File: rtl/johnson_decoder_checker.sv
// Johnson-code receiver: decodes samples, checks single-step advance and tracks lock.
module johnson_decoder_checker
  import johnson_decoder_checker_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned CNT_W    = 8,
  localparam int unsigned IW      = idx_width(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     q_in,
  input  logic             valid_in,
  input  logic             err_clr,
  output logic [IW-1:0]    idx_out,
  output logic [2*N-1:0]   onehot_out,
  output logic             idx_valid,
  output logic             illegal_err,
  output logic             seq_err,
  output logic             locked,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned SW = $clog2(LOCK_CNT + 1);
  localparam int unsigned L  = 2 * N;
  localparam logic [IW-1:0] LAST = IW'(L - 1);

  lock_state_t   state, state_d;
  logic [SW-1:0] streak, streak_d, streak_inc;
  logic [IW-1:0] ref_idx, ref_d, ref_next;
  logic          dec_legal;
  logic [IW-1:0] dec_idx;
  logic          step_ok, seq_hit, err_hit;
  logic [CNT_W-1:0] cnt_d;
  logic [L-1:0]  onehot_d;

  johnson_code_decode #(.N(N)) u_decode (
    .q     (q_in),
    .legal (dec_legal),
    .idx   (dec_idx)
  );

  always_comb begin
    state_d    = state;
    streak_d   = streak;
    ref_d      = ref_idx;
    seq_hit    = 1'b0;
    streak_inc = streak + SW'(1);
    ref_next   = (ref_idx == LAST) ? '0 : ref_idx + IW'(1);
    step_ok    = (dec_idx == ref_next);
    onehot_d   = {{(L-1){1'b0}}, 1'b1} << dec_idx;

    if (valid_in) begin
      if (!dec_legal) begin
        state_d  = UNLOCKED;
        streak_d = '0;
      end else begin
        ref_d = dec_idx;
        case (state)
          UNLOCKED: begin
            state_d  = TRACK;
            streak_d = '0;
          end
          TRACK: begin
            if (step_ok) begin
              if (streak_inc == SW'(LOCK_CNT)) begin
                state_d  = LOCKED;
                streak_d = '0;
              end else begin
                streak_d = streak_inc;
              end
            end else begin
              seq_hit  = 1'b1;
              streak_d = '0;
            end
          end
          LOCKED: begin
            if (!step_ok) begin
              seq_hit  = 1'b1;
              state_d  = TRACK;
              streak_d = '0;
            end
          end
          default: begin
            state_d  = UNLOCKED;
            streak_d = '0;
          end
        endcase
      end
    end

    err_hit = valid_in & (~dec_legal | seq_hit);
    if (err_clr)
      cnt_d = err_hit ? CNT_W'(1) : '0;
    else if (err_hit && (err_count != '1))
      cnt_d = err_count + CNT_W'(1);
    else
      cnt_d = err_count;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= UNLOCKED;
      streak      <= '0;
      ref_idx     <= '0;
      idx_out     <= '0;
      onehot_out  <= '0;
      idx_valid   <= 1'b0;
      illegal_err <= 1'b0;
      seq_err     <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_d;
      streak      <= streak_d;
      ref_idx     <= ref_d;
      illegal_err <= valid_in & ~dec_legal;
      seq_err     <= seq_hit;
      err_count   <= cnt_d;
      if (valid_in) begin
        idx_valid  <= dec_legal;
        onehot_out <= dec_legal ? onehot_d : '0;
        if (dec_legal) idx_out <= dec_idx;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_johnson_decoder_checker.sv
// Bench for johnson_decoder_checker: directed vector table plus randomized model comparison.
module tb_johnson_decoder_checker;

  localparam int LOCK_CNT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] q_in = '0;
  logic       valid_in = 1'b0;
  logic       err_clr = 1'b0;

  logic [2:0] idx_out;
  logic [7:0] onehot_out;
  logic       idx_valid, illegal_err, seq_err, locked;
  logic [7:0] err_count;

  logic [2:0] idx_s;
  logic [7:0] oh_s;
  logic       iv_s, ill_s, seq_s, lk_s;
  logic [1:0] cnt_s;

  johnson_decoder_checker #(.N(4), .LOCK_CNT(LOCK_CNT), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .q_in(q_in), .valid_in(valid_in), .err_clr(err_clr),
    .idx_out(idx_out), .onehot_out(onehot_out), .idx_valid(idx_valid),
    .illegal_err(illegal_err), .seq_err(seq_err), .locked(locked), .err_count(err_count)
  );

  johnson_decoder_checker #(.N(4), .LOCK_CNT(LOCK_CNT), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .q_in(q_in), .valid_in(valid_in), .err_clr(err_clr),
    .idx_out(idx_s), .onehot_out(oh_s), .idx_valid(iv_s),
    .illegal_err(ill_s), .seq_err(seq_s), .locked(lk_s), .err_count(cnt_s)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: legal codes come from stepping an actual Johnson counter;
  // lock is "at least LOCK_CNT correct steps since the reference was established".
  logic [3:0] jcode [8];
  bit m_have_ref;
  int m_ref, m_run, m_idx, m_oh, m_cnt8, m_cnt2;
  bit m_iv, m_ill, m_seq;

  task model_step(input bit r, input bit v, input bit c, input logic [3:0] qq);
    int hit;
    bit err;
    if (!r) begin
      m_have_ref = 0; m_ref = 0; m_run = 0; m_idx = 0; m_oh = 0;
      m_iv = 0; m_ill = 0; m_seq = 0; m_cnt8 = 0; m_cnt2 = 0;
      return;
    end
    m_ill = 0; m_seq = 0; err = 0;
    if (v) begin
      hit = -1;
      for (int j = 0; j < 8; j++) if (jcode[j] == qq) hit = j;
      if (hit < 0) begin
        m_ill = 1; m_iv = 0; m_oh = 0; m_have_ref = 0; m_run = 0; err = 1;
      end else begin
        if (m_have_ref) begin
          if (hit == (m_ref + 1) % 8) begin
            if (m_run < LOCK_CNT) m_run++;
          end else begin
            m_seq = 1; m_run = 0; err = 1;
          end
        end else begin
          m_have_ref = 1; m_run = 0;
        end
        m_ref = hit; m_idx = hit; m_oh = 1 << hit; m_iv = 1;
      end
    end
    if (c) begin
      m_cnt8 = err ? 1 : 0;
      m_cnt2 = err ? 1 : 0;
    end else if (err) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  task automatic apply(input bit r, input bit v, input bit c, input logic [3:0] qq);
    reset = r; valid_in = v; err_clr = c; q_in = qq;
    model_step(r, v, c, qq);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit r, v, c;
    logic [3:0] q;
    int idx, oh;
    bit iv, ill, seq, lk;
    int cnt, cnts;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, v, c, input logic [3:0] qq, input int idx, oh,
                     input bit iv, ill, seq, lk, input int cnt, cnts);
    vec_t e;
    e.r = r; e.v = v; e.c = c; e.q = qq; e.idx = idx; e.oh = oh;
    e.iv = iv; e.ill = ill; e.seq = seq; e.lk = lk; e.cnt = cnt; e.cnts = cnts;
    tbl.push_back(e);
  endtask

  initial begin
    logic [3:0] qq;
    bit r, v, c;

    jcode[0] = 4'b0000;
    for (int i = 1; i < 8; i++) begin
      qq = jcode[i-1];
      jcode[i] = {~qq[0], qq[3:1]};
    end

    //  r  v  c  q        idx oh     iv ill seq lk cnt cnts
    add(0, 1, 0, 4'b1111, 0, 'h00, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'b1111, 0, 'h00, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 4'b1111, 0, 'h00, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 4'b0000, 0, 'h01, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 4'b1000, 1, 'h02, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 4'b1100, 2, 'h04, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 4'b1110, 3, 'h08, 1, 0, 0, 1, 0, 0);
    add(1, 1, 0, 4'b1111, 4, 'h10, 1, 0, 0, 1, 0, 0);
    add(1, 1, 0, 4'b0111, 5, 'h20, 1, 0, 0, 1, 0, 0);
    add(1, 1, 0, 4'b0011, 6, 'h40, 1, 0, 0, 1, 0, 0);
    add(1, 1, 0, 4'b0001, 7, 'h80, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      add(1, 0, 0, 4'b0101, 7, 'h80, 1, 0, 0, 1, 0, 0);
    add(1, 1, 0, 4'b0000, 0, 'h01, 1, 0, 0, 1, 0, 0);
    add(1, 1, 0, 4'b0101, 0, 'h00, 0, 1, 0, 0, 1, 1);
    add(1, 1, 0, 4'b1000, 1, 'h02, 1, 0, 0, 0, 1, 1);
    add(1, 1, 0, 4'b1100, 2, 'h04, 1, 0, 0, 0, 1, 1);
    add(1, 1, 0, 4'b1110, 3, 'h08, 1, 0, 0, 0, 1, 1);
    add(1, 1, 0, 4'b1111, 4, 'h10, 1, 0, 0, 1, 1, 1);
    add(1, 1, 0, 4'b0111, 5, 'h20, 1, 0, 0, 1, 1, 1);
    add(1, 1, 0, 4'b0011, 6, 'h40, 1, 0, 0, 1, 1, 1);
    add(1, 1, 0, 4'b0001, 7, 'h80, 1, 0, 0, 1, 1, 1);
    add(1, 1, 0, 4'b0000, 0, 'h01, 1, 0, 0, 1, 1, 1);
    add(1, 1, 0, 4'b1000, 1, 'h02, 1, 0, 0, 1, 1, 1);
    add(1, 1, 0, 4'b1100, 2, 'h04, 1, 0, 0, 1, 1, 1);
    add(1, 1, 0, 4'b1111, 4, 'h10, 1, 0, 1, 0, 2, 2);
    add(1, 1, 0, 4'b0111, 5, 'h20, 1, 0, 0, 0, 2, 2);
    add(1, 1, 0, 4'b0011, 6, 'h40, 1, 0, 0, 0, 2, 2);
    add(1, 1, 0, 4'b0001, 7, 'h80, 1, 0, 0, 1, 2, 2);
    add(1, 1, 0, 4'b0001, 7, 'h80, 1, 0, 1, 0, 3, 3);
    add(1, 1, 0, 4'b0000, 0, 'h01, 1, 0, 0, 0, 3, 3);
    add(1, 1, 0, 4'b0101, 0, 'h00, 0, 1, 0, 0, 4, 3);
    add(1, 1, 0, 4'b1010, 0, 'h00, 0, 1, 0, 0, 5, 3);
    add(1, 0, 1, 4'b0000, 0, 'h00, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 4'b1001, 0, 'h00, 0, 1, 0, 0, 1, 1);
    add(1, 1, 0, 4'b0100, 0, 'h00, 0, 1, 0, 0, 2, 2);
    add(1, 1, 0, 4'b0110, 0, 'h00, 0, 1, 0, 0, 3, 3);
    add(1, 1, 0, 4'b1101, 0, 'h00, 0, 1, 0, 0, 4, 3);

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].q);
      check($sformatf("row%0d idx_out", i),     idx_out,     tbl[i].idx);
      check($sformatf("row%0d onehot_out", i),  onehot_out,  tbl[i].oh);
      check($sformatf("row%0d idx_valid", i),   idx_valid,   tbl[i].iv);
      check($sformatf("row%0d illegal_err", i), illegal_err, tbl[i].ill);
      check($sformatf("row%0d seq_err", i),     seq_err,     tbl[i].seq);
      check($sformatf("row%0d locked", i),      locked,      tbl[i].lk);
      check($sformatf("row%0d err_count", i),   err_count,   tbl[i].cnt);
      check($sformatf("row%0d err_count_w2", i), cnt_s,      tbl[i].cnts);
    end

    for (int n = 0; n < 500; n++) begin
      r = ($urandom_range(0, 99) >= 2);
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) < 7)      qq = jcode[(m_ref + 1) % 8];
      else if ($urandom_range(0, 1) == 0) qq = jcode[$urandom_range(0, 7)];
      else                               qq = 4'($urandom);
      apply(r, v, c, qq);
      check($sformatf("rnd%0d idx_out", n),     idx_out,     m_idx);
      check($sformatf("rnd%0d onehot_out", n),  onehot_out,  m_oh);
      check($sformatf("rnd%0d idx_valid", n),   idx_valid,   m_iv);
      check($sformatf("rnd%0d illegal_err", n), illegal_err, m_ill);
      check($sformatf("rnd%0d seq_err", n),     seq_err,     m_seq);
      check($sformatf("rnd%0d locked", n),      locked,      (m_have_ref && m_run >= LOCK_CNT));
      check($sformatf("rnd%0d err_count", n),   err_count,   m_cnt8);
      check($sformatf("rnd%0d err_count_w2", n), cnt_s,      m_cnt2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/johnson_decoder_checker.md
Name: johnson_decoder_checker

Overview:
Receive-side companion to the team's 4-bit Johnson counter. It samples an N-bit Johnson-coded state, decodes it to a binary index and a one-hot vector, and checks that the code is legal and that it advances by exactly one step per valid sample. A lock FSM reports when the incoming sequence is trusted. An error counter supports monitoring and bring-up.

Parameters:
N, 4, Johnson register width; the sequence length is 2N.
LOCK_CNT, 3, number of consecutive correct steps needed to enter LOCKED (must be at least 1).
CNT_W, 8, width of the saturating error counter.
IW (localparam), $clog2(2N), index width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-low reset (reset=0 resets on the next rising clk edge).
q_in  in  N  Johnson-coded state; bit N-1 is the bit loaded with the inverted LSB.
valid_in  in  1  q_in is sampled this cycle.
err_clr  in  1  synchronous clear of err_count.
idx_out  out  IW  decoded index 0..2N-1.
onehot_out  out  2N  one-hot of idx_out; all zero when the sample is not valid or is illegal.
idx_valid  out  1  idx_out and onehot_out correspond to a legal sample taken last cycle.
illegal_err  out  1  one-cycle pulse: the sample was not a legal Johnson code.
seq_err  out  1  one-cycle pulse: the sample was legal but out of sequence.
locked  out  1  the lock FSM is in LOCKED.
err_count  out  CNT_W  saturating count of error samples.

Behaviour:
- Reset (reset=0, sampled at the edge): every output goes to 0, the FSM goes to UNLOCKED, and the streak and reference are cleared. Reset overrides valid_in and err_clr.
- Legality: a code is legal iff the number of adjacent-bit transitions between q_in[i] and q_in[i-1], for i=N-1..1, is at most 1. This gives exactly 2N legal codes.
- Decode: let k be the popcount. If q_in[0]=0, idx=k. Otherwise idx=N+(N-k).
  - N=4 mapping: 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7.
- Latency: registered outputs, one cycle after the sampling edge.
- valid_in=0: idx_out, onehot_out and idx_valid hold their values. The pulse outputs are 0. FSM, streak and reference are unchanged. No timeout applies.
- Illegal sample:
  - illegal_err=1, seq_err=0, idx_valid=0, onehot_out=0, idx_out holds.
  - FSM goes to UNLOCKED.
- Legal sample: idx_valid=1, idx_out=idx, onehot_out=1<<idx. The reference is updated to idx.
- Step check: a step is correct iff idx == (ref+1) mod 2N. The wrap from 2N-1 to 0 is correct. A repeated index is a seq error.
- Lock FSM:
  - UNLOCKED: a legal sample sets the reference and moves to TRACK with streak=0. No seq check is made.
  - TRACK: a correct step does streak+1; when streak+1 equals LOCK_CNT, go to LOCKED. A wrong legal step gives seq_err=1 and streak=0, and the FSM stays in TRACK (resync to the new index). An illegal sample goes to UNLOCKED.
  - LOCKED: a correct step stays in LOCKED. A wrong legal step gives seq_err and goes to TRACK with streak=0. An illegal sample goes to UNLOCKED.
  - locked=1 is visible in the same cycle as the idx_out of the locking sample.
- err_count:
  - Increments by 1 per sample with illegal_err or seq_err, and saturates at all ones.
  - err_clr alone sets it to 0.
  - err_clr together with an error sets it to 1.

Decomposition:
- Shared package: lock FSM state encoding (UNLOCKED=0, TRACK=1, LOCKED=2) and the index-width helper function.
- One combinational sub-module, johnson_code_decode (parameter N). Input q; outputs legal and idx. It is reusable by other Johnson-counter consumers.
- The top level holds the registers, the FSM, the step check and the counter.

Test Plan:
- Reset: hold reset=0 for 2 cycles with valid_in=1, q_in=1111 -> all outputs 0; after release with valid_in=0, outputs stay 0.
- Clean run, N=4, LOCK_CNT=3: 0000,1000,1100,1110 on consecutive cycles -> idx_out 0,1,2,3; onehot 01,02,04,08; locked=1 alongside idx_out=3; no error pulses.
- Wrap plus gaps while LOCKED: 0011,0001, valid_in=0 for 5 cycles, then 0000 -> idx 6,7,0; outputs hold during the gap; locked stays 1; err_count=0.
- Illegal code while LOCKED: 0101 -> one-cycle illegal_err; idx_valid=0; onehot=0; locked=0; err_count 0->1. Next 1000 -> FSM in TRACK with no seq_err.
- Skip while LOCKED: 1100 then 1111 -> seq_err pulse, locked=0, err_count+1. Then 0111, 0011, 0001 -> locked=1 after the third correct step.
- Saturation and clear, CNT_W=2: five illegal samples -> err_count=3. err_clr alone -> 0. err_clr plus an illegal sample -> 1.
